// File: rtl/funcase_pkg.sv
// Shared types, symbol codes and the flag-to-symbol encoder for the
// funcase encoder slice.
package funcase_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [1:0] SYM_ONE   = 2'h3;
    localparam logic [1:0] SYM_ZERO0 = 2'h0;
    localparam logic [1:0] SYM_ZERO1 = 2'h1;
    localparam logic [1:0] SYM_ZERO2 = 2'h2;

    // A one always maps to SYM_ONE; a zero takes the current rotation code.
    function automatic logic [1:0] encode(input bit b,
                                          input logic [1:0] rot);
        return b ? SYM_ONE : rot;
    endfunction

endpackage

// File: rtl/funcase_bit_fifo.sv
// DEPTH x 1-bit synchronous FIFO with asynchronous active-low clear.
// Ports: push/din write, pop read, head = oldest entry, full/empty flags.
module funcase_bit_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is refused even when a pop frees a slot.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign head  = mem[rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem  <= '0;
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/funcase_encoder.sv
// Flag-to-line-symbol encoder: FIFO-buffered flags, preamble of ones,
// zeros sent as rotating 0/1/2 when FUNCASE_ROTATE_EN is defined (else 0).
// Ports: clk; rst (async, active-low);
//   __in0  = {in_valid, in_bit, out_ready}
//   __out0 = {in_ready, out_valid, sym[1:0]}
module funcase_encoder
    import funcase_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int PREAMBLE_LEN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] __in0,
    output logic [3:0] __out0
);

    localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN - 1);

    logic       in_valid;
    logic       in_bit;
    logic       out_ready;
    logic       in_ready;
    logic       out_valid;
    logic [1:0] sym;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] pre_cnt;
    logic [3:0] pre_nxt;
    logic       push;
    logic       pop;
    logic       head;
    logic       full;
    logic       empty;

    assign in_valid  = __in0[2];
    assign in_bit    = __in0[1];
    assign out_ready = __in0[0];
    assign __out0    = {in_ready, out_valid, sym};

    funcase_bit_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  (in_bit),
        .pop  (pop),
        .head (head),
        .full (full),
        .empty(empty)
    );

`ifdef FUNCASE_ROTATE_EN
    logic [1:0] rot;
    logic [1:0] rot_adv;

    // Rotation wraps after 2 so a zero never aliases the SYM_ONE code.
    always_comb begin
        unique case (rot)
            SYM_ZERO0: rot_adv = SYM_ZERO1;
            SYM_ZERO1: rot_adv = SYM_ZERO2;
            default:   rot_adv = SYM_ZERO0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rot <= SYM_ZERO0;
        end else if (pop && !head) begin
            rot <= rot_adv;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pre_cnt <= '0;
        end else begin
            state   <= state_nxt;
            pre_cnt <= pre_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pre_nxt   = pre_cnt;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        sym       = 2'h0;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                state_nxt = PRE;
            end
            PRE: begin
                in_ready  = !full;
                out_valid = 1'b1;
                sym       = SYM_ONE;
                if (out_ready) begin
                    pre_nxt = pre_cnt + 4'd1;
                    if (pre_cnt == PRE_LAST) begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                in_ready  = !full;
                out_valid = !empty;
`ifdef FUNCASE_ROTATE_EN
                sym       = encode(head, rot);
`else
                sym       = encode(head, SYM_ZERO0);
`endif
                pop       = !empty && out_ready;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        push = in_valid && in_ready;
    end

endmodule
